mem_port_sequencer: RTL and testbench

MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

---
 rtl/memseq_pkg.sv | 15 +
 rtl/mem_port_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mem_port_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/memseq_pkg.sv
// Shared types and phase constants for the memory port sequencer.
package memseq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        WR,
        RSP
    } state_t;

    localparam logic [1:0] PH_READ  = 2'b00;
    localparam logic [1:0] PH_WRITE = 2'b10;

endpackage

// File: rtl/mem_port_sequencer.sv
// Sequences one request (two reads, optional write) onto a phased 1w1r memory
// port and returns both read results through a valid/ready response.
module mem_port_sequencer
    import memseq_pkg::*;
#(
    parameter int ELEMENTS_W = 7,
    parameter int WIDTH      = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            counter,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ELEMENTS_W-1:0] req_raddr_a,
    input  logic [ELEMENTS_W-1:0] req_raddr_b,
    input  logic                  req_we,
    input  logic [ELEMENTS_W-1:0] req_waddr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata_a,
    output logic [WIDTH-1:0]      rsp_rdata_b,
    output logic [ELEMENTS_W-1:0] mem_raddr,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic [ELEMENTS_W-1:0] mem_waddr,
    output logic                  mem_write,
    output logic [WIDTH-1:0]      mem_wdata
);

    state_t                  state;
    state_t                  state_next;
    logic                    issued;
    logic                    issued_next;
    logic                    cap_a;
    logic                    cap_b;
    logic                    accept;
    logic                    write_live;

    logic [ELEMENTS_W-1:0]   addr_a;
    logic [ELEMENTS_W-1:0]   addr_b;
    logic                    we;
    logic [ELEMENTS_W-1:0]   waddr;
    logic [WIDTH-1:0]        wdata;

    // Address 0 behaves as a hard-wired zero register when enabled.
    function automatic logic suppressed(input logic [ELEMENTS_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign accept     = req_valid && req_ready;
    assign write_live = we && !suppressed(waddr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            issued <= 1'b0;
        end else begin
            state  <= state_next;
            issued <= issued_next;
        end
    end

    // A read is issued on the first counter==PH_READ edge; the memory's
    // registered output is then captured on the following edge.
    always_comb begin
        state_next  = state;
        issued_next = issued;
        cap_a       = 1'b0;
        cap_b       = 1'b0;
        case (state)
            IDLE: begin
                issued_next = 1'b0;
                if (accept) begin
                    if (suppressed(req_raddr_a) && suppressed(req_raddr_b)) begin
                        state_next = WR;
                    end else if (suppressed(req_raddr_a)) begin
                        state_next = RD_B;
                    end else begin
                        state_next = RD_A;
                    end
                end
            end
            RD_A: begin
                if (!issued) begin
                    if (counter == PH_READ) begin
                        issued_next = 1'b1;
                    end
                end else begin
                    cap_a       = 1'b1;
                    issued_next = 1'b0;
                    if (addr_b == addr_a) begin
                        cap_b      = 1'b1;
                        state_next = WR;
                    end else if (suppressed(addr_b)) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_B;
                    end
                end
            end
            RD_B: begin
                if (!issued) begin
                    if (counter == PH_READ) begin
                        issued_next = 1'b1;
                    end
                end else begin
                    cap_b       = 1'b1;
                    issued_next = 1'b0;
                    state_next  = WR;
                end
            end
            WR: begin
                if (!write_live || (counter == PH_WRITE)) begin
                    state_next = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Results start at zero on accept so suppressed reads need no extra work.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_a      <= '0;
            addr_b      <= '0;
            we          <= 1'b0;
            waddr       <= '0;
            wdata       <= '0;
            rsp_rdata_a <= '0;
            rsp_rdata_b <= '0;
        end else begin
            if (accept) begin
                addr_a      <= req_raddr_a;
                addr_b      <= req_raddr_b;
                we          <= req_we;
                waddr       <= req_waddr;
                wdata       <= req_wdata;
                rsp_rdata_a <= '0;
                rsp_rdata_b <= '0;
            end
            if (cap_a) begin
                rsp_rdata_a <= mem_rdata;
            end
            if (cap_b) begin
                rsp_rdata_b <= mem_rdata;
            end
        end
    end

    // Gating with rst_n keeps an in-flight write from landing on the reset edge.
    assign req_ready = rst_n && (state == IDLE);
    assign rsp_valid = (state == RSP);
    assign mem_write = rst_n && (state == WR) && write_live;
    assign mem_raddr = (state == IDLE) ? '0 : ((state == RD_B) ? addr_b : addr_a);
    assign mem_waddr = (state == IDLE) ? '0 : waddr;
    assign mem_wdata = (state == IDLE) ? '0 : wdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench: sequencer paired with a phased 1w1r memory and free-running counter.
module tb_mem_port_sequencer;
    import memseq_pkg::*;

    typedef struct {
        logic [6:0]  a;
        logic [6:0]  b;
        logic        we;
        logic [6:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int          max_lat;
        int          exp_wr;
        int          exp_rdb;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  counter = 2'b00;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_raddr_a = '0;
    logic [6:0]  req_raddr_b = '0;
    logic        req_we = 1'b0;
    logic [6:0]  req_waddr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata_a;
    logic [31:0] rsp_rdata_b;
    logic [6:0]  mem_raddr;
    logic [31:0] mem_rdata = '0;
    logic [6:0]  mem_waddr;
    logic        mem_write;
    logic [31:0] mem_wdata;

    logic [31:0] mem [128];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    int          landed = 0;
    int          wr_hi = 0;
    int          rdb = 0;

    int          tests = 0;
    int          failed = 0;
    rsp_t        exp_q [$];
    vec_t        vecs [7];
    vec_t        tail;

    mem_port_sequencer #(
        .ELEMENTS_W (7),
        .WIDTH      (32),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .counter     (counter),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_raddr_a (req_raddr_a),
        .req_raddr_b (req_raddr_b),
        .req_we      (req_we),
        .req_waddr   (req_waddr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata_a (rsp_rdata_a),
        .rsp_rdata_b (rsp_rdata_b),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_waddr   (mem_waddr),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) counter <= counter + 2'd1;

    // Memory: registered read on the 00 phase, write on the 10 phase.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (counter == 2'b10 && mem_write) begin
            mem[mem_waddr] <= mem_wdata;
            landed <= landed + 1;
        end
        if (counter == 2'b00) mem_rdata <= mem[mem_raddr];
        if (mem_write) wr_hi <= wr_hi + 1;
        if (dut.state == RD_B) rdb <= rdb + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [6:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        pre_we = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic run_req(input vec_t v, input int idx);
        int   lat;
        int   landed0;
        int   wr_hi0;
        int   rdb0;
        rsp_t e;
        landed0 = landed;
        wr_hi0 = wr_hi;
        rdb0 = rdb;
        @(posedge clk);
        #1;
        req_raddr_a = v.a;
        req_raddr_b = v.b;
        req_we = v.we;
        req_waddr = v.waddr;
        req_wdata = v.wdata;
        req_valid = 1'b1;
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back('{v.exp_a, v.exp_b});
        #1;
        req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++;
        if (!rsp_valid || lat > v.max_lat) begin
            failed++;
            $display("FAIL v%0d_latency: got %0d cycles (valid=%0d) limit %0d", idx, lat, rsp_valid, v.max_lat);
        end
        for (int i = 0; i < v.hold; i++) begin
            check($sformatf("v%0d_hold%0d_valid", idx, i), 32'(rsp_valid), 32'd1);
            check($sformatf("v%0d_hold%0d_req_ready", idx, i), 32'(req_ready), 32'd0);
            check($sformatf("v%0d_hold%0d_a", idx, i), rsp_rdata_a, v.exp_a);
            check($sformatf("v%0d_hold%0d_b", idx, i), rsp_rdata_b, v.exp_b);
            @(negedge clk);
        end
        tests++;
        if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL v%0d_scoreboard: got empty queue expected one entry", idx);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("v%0d_rsp_a", idx), rsp_rdata_a, e.a);
            check($sformatf("v%0d_rsp_b", idx), rsp_rdata_b, e.b);
        end
        rsp_ready = rsp_valid;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_idle_valid", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d_idle_ready", idx), 32'(req_ready), 32'd1);
        check($sformatf("v%0d_writes", idx), 32'(landed - landed0), 32'(v.exp_wr));
        if (v.exp_wr == 0)
            check($sformatf("v%0d_mem_write_level", idx), 32'(wr_hi - wr_hi0), 32'd0);
        check($sformatf("v%0d_rd_b_used", idx), 32'(rdb > rdb0), 32'(v.exp_rdb));
    endtask

    initial begin
        int n;
        int landed0;
        // a, b, we, waddr, wdata, exp_a, exp_b, max_lat, exp_wr, exp_rdb, hold
        vecs[0] = '{7'd5,  7'd9,  1'b0, 7'd0,  32'h0,        32'hA5A5A5A5, 32'h12345678, 13, 0, 1, 10};
        vecs[1] = '{7'd7,  7'd7,  1'b1, 7'd7,  32'hDEADBEEF, 32'h00000001, 32'h00000001, 13, 1, 0, 0};
        vecs[2] = '{7'd7,  7'd0,  1'b0, 7'd0,  32'h0,        32'hDEADBEEF, 32'h00000000, 13, 0, 0, 0};
        vecs[3] = '{7'd0,  7'd0,  1'b1, 7'd0,  32'hFFFFFFFF, 32'h00000000, 32'h00000000, 2,  0, 0, 0};
        vecs[4] = '{7'd0,  7'd3,  1'b1, 7'd12, 32'h5555AAAA, 32'h00000000, 32'h33333333, 13, 1, 1, 0};
        vecs[5] = '{7'd12, 7'd9,  1'b1, 7'd9,  32'h00000099, 32'h5555AAAA, 32'h12345678, 13, 1, 1, 0};
        vecs[6] = '{7'd9,  7'd12, 1'b0, 7'd0,  32'h0,        32'h00000099, 32'h5555AAAA, 13, 0, 1, 0};
        tail    = '{7'd3,  7'd5,  1'b0, 7'd0,  32'h0,        32'h33333333, 32'hA5A5A5A5, 13, 0, 1, 0};

        preload(7'd0,  32'hCAFE0000);
        preload(7'd3,  32'h33333333);
        preload(7'd5,  32'hA5A5A5A5);
        preload(7'd7,  32'h00000001);
        preload(7'd9,  32'h12345678);
        preload(7'd12, 32'hC0C0C0C0);

        @(negedge clk);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_mem_write", 32'(mem_write), 32'd0);
        check("reset_rdata_a", rsp_rdata_a, 32'd0);
        check("reset_rdata_b", rsp_rdata_b, 32'd0);
        check("reset_mem_raddr", 32'(mem_raddr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_req(vecs[i], i);

        check("mem0_untouched", mem[0], 32'hCAFE0000);
        check("mem7_written", mem[7], 32'hDEADBEEF);

        // Reset lands on the write-phase edge of a live write.
        landed0 = landed;
        @(posedge clk);
        #1;
        req_raddr_a = 7'd3;
        req_raddr_b = 7'd3;
        req_we = 1'b1;
        req_waddr = 7'd3;
        req_wdata = 32'h77777777;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(mem_write && counter == 2'b10) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_wr", 32'(mem_write && counter == 2'b10), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req_ready_low", 32'(req_ready), 32'd0);
        check("rst_mem_write_low", 32'(mem_write), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_req_ready", 32'(req_ready), 32'd1);
        check("rst_release_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("rst_no_write_landed", 32'(landed - landed0), 32'd0);
        check("rst_mem3_intact", mem[3], 32'h33333333);
        check("rst_idle_after", 32'(req_ready), 32'd1);

        run_req(tail, 7);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
